// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared types and constants for the vending purchase/restock sequencer:
//   - vend_state_e : FSM state encoding (also driven out on state_o)
//   - CAPACITY_DEF : default per-slot capacity
//   - STOCK_W / CREDIT_W / COIN_W : datapath widths
//   - price_lookup : maps a slot index onto its configured price
// -----------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAY      = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_REFUND   = 3'd4
  } vend_state_e;

  localparam int CAPACITY_DEF = 15;
  localparam int NUM_SLOTS    = 4;
  localparam int STOCK_W      = 4;
  localparam int CREDIT_W     = 6;
  localparam int COIN_W       = 4;

  // Prices stay module parameters of the top; this just selects one of them.
  function automatic logic [CREDIT_W-1:0] price_lookup(input logic [1:0] slot,
                                                       input int p0, input int p1,
                                                       input int p2, input int p3);
    int p;
    case (slot)
      2'd0:    p = p0;
      2'd1:    p = p1;
      2'd2:    p = p2;
      default: p = p3;
    endcase
    return CREDIT_W'(p);
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// -----------------------------------------------------------------------------
// vend_stock_bank
// Four per-slot stock counters. A restock adds add_qty to one slot with
// saturation at CAPACITY; a dispense removes one unit from one slot and never
// wraps below zero.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (stock -> CAPACITY)
//   dec_en, dec_slot    remove one unit from dec_slot
//   add_en, add_slot,   add add_qty units to add_slot (saturating)
//   add_qty
//   stock               {slot3, slot2, slot1, slot0}, STOCK_W bits each
// -----------------------------------------------------------------------------
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_en,
  input  logic [1:0]                   dec_slot,
  input  logic                         add_en,
  input  logic [1:0]                   add_slot,
  input  logic [STOCK_W-1:0]           add_qty,
  output logic [NUM_SLOTS*STOCK_W-1:0] stock
);

  localparam logic [STOCK_W:0] CAP = (STOCK_W + 1)'(CAPACITY);

  logic [STOCK_W-1:0] slot_q [NUM_SLOTS];
  logic [STOCK_W-1:0] slot_d [NUM_SLOTS];
  logic [STOCK_W:0]   add_sum;
  logic [STOCK_W-1:0] add_sat;

  // One extra bit so the overflowing sum is seen before saturating.
  assign add_sum = {1'b0, slot_q[add_slot]} + {1'b0, add_qty};
  assign add_sat = (add_sum > CAP) ? CAP[STOCK_W-1:0] : add_sum[STOCK_W-1:0];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // NOTE: every slot_d gets its hold value first, so no path leaves it
      // unassigned and no latch is inferred.
      slot_d[i] = slot_q[i];
      if (add_en && add_slot == 2'(i)) begin
        slot_d[i] = add_sat;
      end else if (dec_en && dec_slot == 2'(i) && slot_q[i] != '0) begin
        slot_d[i] = slot_q[i] - STOCK_W'(1);
      end
    end
  end

  // NOTE: this register array is reset (to full) because stock is visible
  // architectural state; a large RAM-style memory would normally not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= CAP[STOCK_W-1:0];
    end else begin
      // NOTE: non-blocking assignment for all clocked state so every register
      // samples the pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign stock[g*STOCK_W +: STOCK_W] = slot_q[g];
  end

endmodule

// File: rtl/vend_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vend_seq_ctrl
// Purchase/restock sequencer for the 4-slot vending datapath:
// select -> pay -> dispense -> change, with admin restock arbitrated against
// customer purchases (restock only in IDLE, purchase wins ties).
// All outputs are registered.
// Optional feature macro: VEND_TIMEOUT_EN -- when defined, PAY auto-refunds
// after TIMEOUT_CYCLES cycles without an accepted coin.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   sel_valid, sel_slot              customer slot selection pulse
//   coin_valid, coin_val             coin insertion pulse and value
//   cancel                           customer abort pulse
//   restock_valid/_slot/_qty         admin restock request (held until ready)
//   restock_ready                    restock accepted (1-cycle pulse)
//   stock                            {slot3..slot0} stock, 4 bits each
//   state_o, cur_slot, credit        FSM state, active slot, inserted credit
//   dispense                         item released (1-cycle pulse)
//   change_valid, change_amt         change/refund amount valid pulse
//   err                              rejected selection or coin (1-cycle pulse)
// -----------------------------------------------------------------------------
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int PRICE0   = 3,
  parameter int PRICE1   = 5,
  parameter int PRICE2   = 7,
  parameter int PRICE3   = 9
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 100000000
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sel_valid,
  input  logic [1:0]                   sel_slot,
  input  logic                         coin_valid,
  input  logic [COIN_W-1:0]            coin_val,
  input  logic                         cancel,
  input  logic                         restock_valid,
  input  logic [1:0]                   restock_slot,
  input  logic [STOCK_W-1:0]           restock_qty,
  output logic                         restock_ready,
  output logic [NUM_SLOTS*STOCK_W-1:0] stock,
  output logic [2:0]                   state_o,
  output logic [1:0]                   cur_slot,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         dispense,
  output logic                         change_valid,
  output logic [CREDIT_W-1:0]          change_amt,
  output logic                         err
);

  vend_state_e         state_q, state_d;
  logic [1:0]          cur_slot_q, cur_slot_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic                err_q, err_d;
  logic                restock_ready_q, restock_ready_d;
  logic                add_en, dec_en;
  logic                timeout_hit;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] price;

  assign price    = price_lookup(cur_slot_q, PRICE0, PRICE1, PRICE2, PRICE3);
  assign coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);

  vend_stock_bank #(.CAPACITY(CAPACITY)) u_stock (
    .clk      (clk),
    .rst      (rst),
    .dec_en   (dec_en),
    .dec_slot (cur_slot_q),
    .add_en   (add_en),
    .add_slot (restock_slot),
    .add_qty  (restock_qty),
    .stock    (stock)
  );

  always_comb begin
    state_d         = state_q;
    cur_slot_d      = cur_slot_q;
    credit_d        = credit_q;
    change_amt_d    = change_amt_q;
    dispense_d      = 1'b0;
    change_valid_d  = 1'b0;
    err_d           = 1'b0;
    restock_ready_d = 1'b0;
    add_en          = 1'b0;
    dec_en          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (stock[{sel_slot, 2'b00} +: STOCK_W] != '0) begin
            cur_slot_d = sel_slot;
            state_d    = ST_PAY;
          end else begin
            err_d = 1'b1;
          end
        end else if (restock_valid) begin
          add_en          = 1'b1;
          restock_ready_d = 1'b1;
        end
        if (coin_valid && coin_val != '0) err_d = 1'b1;
      end

      ST_PAY: begin
        if (cancel || timeout_hit) begin
          state_d        = ST_REFUND;
          change_amt_d   = credit_q;
          change_valid_d = 1'b1;
        end else begin
          if (coin_valid && coin_val != '0) begin
            if (coin_sum > (CREDIT_W + 1)'(2**CREDIT_W - 1)) err_d = 1'b1;
            else                                             credit_d = coin_sum[CREDIT_W-1:0];
          end
          // Uses the registered credit, so the qualifying coin costs one cycle
          // here and one more to raise dispense.
          if (credit_q >= price) begin
            state_d    = ST_DISPENSE;
            dispense_d = 1'b1;
          end
        end
      end

      ST_DISPENSE: begin
        dec_en         = 1'b1;
        change_amt_d   = credit_q - price;
        change_valid_d = 1'b1;
        state_d        = ST_CHANGE;
      end

      ST_CHANGE, ST_REFUND: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cur_slot_q      <= '0;
      credit_q        <= '0;
      change_amt_q    <= '0;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      err_q           <= 1'b0;
      restock_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_slot_q      <= cur_slot_d;
      credit_q        <= credit_d;
      change_amt_q    <= change_amt_d;
      dispense_q      <= dispense_d;
      change_valid_q  <= change_valid_d;
      err_q           <= err_d;
      restock_ready_q <= restock_ready_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // In PAY, credit only moves when a coin is accepted, which restarts the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          to_cnt_q <= '0;
    else if (state_q != ST_PAY || credit_d != credit_q) to_cnt_q <= '0;
    else if (!timeout_hit)                            to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timeout_hit = (state_q == ST_PAY) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign state_o       = state_q;
  assign cur_slot      = cur_slot_q;
  assign credit        = credit_q;
  assign change_amt    = change_amt_q;
  assign dispense      = dispense_q;
  assign change_valid  = change_valid_q;
  assign err           = err_q;
  assign restock_ready = restock_ready_q;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_seq_ctrl
// Directed bench for vend_seq_ctrl. PRICE3 is raised to 63 so the 6-bit credit
// ceiling can be reached; the other prices keep their defaults (3, 5, 7).
// With VEND_TIMEOUT_EN defined the DUT gets TIMEOUT_CYCLES=20.
// -----------------------------------------------------------------------------
module tb_vend_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_valid;
  logic [1:0]  sel_slot;
  logic        coin_valid;
  logic [3:0]  coin_val;
  logic        cancel;
  logic        restock_valid;
  logic [1:0]  restock_slot;
  logic [3:0]  restock_qty;
  logic        restock_ready;
  logic [15:0] stock;
  logic [2:0]  state_o;
  logic [1:0]  cur_slot;
  logic [5:0]  credit;
  logic        dispense;
  logic        change_valid;
  logic [5:0]  change_amt;
  logic        err;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_PAY = 3'd1, S_DISP = 3'd2,
                         S_CHG = 3'd3, S_REF = 3'd4;

  vend_seq_ctrl #(
    .PRICE3(63)
`ifdef VEND_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_valid     (sel_valid),
    .sel_slot      (sel_slot),
    .coin_valid    (coin_valid),
    .coin_val      (coin_val),
    .cancel        (cancel),
    .restock_valid (restock_valid),
    .restock_slot  (restock_slot),
    .restock_qty   (restock_qty),
    .restock_ready (restock_ready),
    .stock         (stock),
    .state_o       (state_o),
    .cur_slot      (cur_slot),
    .credit        (credit),
    .dispense      (dispense),
    .change_valid  (change_valid),
    .change_amt    (change_amt),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [1:0] s);
    sel_valid = 1'b1;
    sel_slot  = s;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    step();
    coin_valid = 1'b0;
    coin_val   = '0;
  endtask

  function automatic logic [3:0] slot_stock(input int s);
    return stock[s*4 +: 4];
  endfunction

  initial begin
    rst = 1'b1;
    sel_valid = 0; sel_slot = 0; coin_valid = 0; coin_val = 0; cancel = 0;
    restock_valid = 0; restock_slot = 0; restock_qty = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 16'(state_o), 16'(S_IDLE));
    check("rst_stock", stock, 16'hFFFF);
    check("rst_credit", 16'(credit), 16'd0);
    check("rst_cur_slot", 16'(cur_slot), 16'd0);
    check("rst_pulses", 16'({dispense, change_valid, err, restock_ready}), 16'd0);
    check("rst_change_amt", 16'(change_amt), 16'd0);
    rst = 1'b0;
    step();

    // Slot 1 (price 5), coins 2,2,2 -> change 1
    sel(2'd1);
    check("a_pay", 16'(state_o), 16'(S_PAY));
    check("a_cur_slot", 16'(cur_slot), 16'd1);
    sel(2'd2);  // ignored outside IDLE
    check("a_sel_ignored_slot", 16'(cur_slot), 16'd1);
    check("a_sel_ignored_err", 16'(err), 16'd0);
    coin(4'd2);
    coin(4'd2);
    check("a_credit4", 16'(credit), 16'd4);
    coin(4'd2);
    check("a_credit6", 16'(credit), 16'd6);
    check("a_no_disp_yet", 16'(dispense), 16'd0);
    step();
    check("a_dispense", 16'(dispense), 16'd1);
    check("a_state_disp", 16'(state_o), 16'(S_DISP));
    step();
    check("a_change_valid", 16'(change_valid), 16'd1);
    check("a_change_amt", 16'(change_amt), 16'd1);
    check("a_stock1", 16'(slot_stock(1)), 16'd14);
    check("a_disp_cleared", 16'(dispense), 16'd0);
    step();
    check("a_idle", 16'(state_o), 16'(S_IDLE));
    check("a_credit_clr", 16'(credit), 16'd0);

    // Coin in IDLE is rejected
    coin(4'd4);
    check("idle_coin_err", 16'(err), 16'd1);
    check("idle_coin_credit", 16'(credit), 16'd0);
    step();
    check("idle_err_pulse", 16'(err), 16'd0);

    // Slot 0 (price 3), exact coin -> change 0
    sel(2'd0);
    coin(4'd3);
    step();
    check("b_dispense", 16'(dispense), 16'd1);
    step();
    check("b_change_valid", 16'(change_valid), 16'd1);
    check("b_change_amt", 16'(change_amt), 16'd0);
    check("b_stock0", 16'(slot_stock(0)), 16'd14);
    step();

    // Slot 3, coin 5, cancel -> refund 5
    sel(2'd3);
    coin(4'd5);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("c_refund", 16'(state_o), 16'(S_REF));
    check("c_refund_valid", 16'(change_valid), 16'd1);
    check("c_refund_amt", 16'(change_amt), 16'd5);
    check("c_stock3", 16'(slot_stock(3)), 16'd15);
    step();
    check("c_idle", 16'(state_o), 16'(S_IDLE));
    check("c_credit_clr", 16'(credit), 16'd0);

    // Empty slot 2 (price 7), then try to select it
    for (int n = 0; n < 15; n++) begin
      sel(2'd2);
      coin(4'd7);
      repeat (3) step();
    end
    check("d_stock_all", stock, 16'hF0EE);
    sel(2'd2);
    check("d_empty_err", 16'(err), 16'd1);
    check("d_empty_idle", 16'(state_o), 16'(S_IDLE));
    step();
    check("d_err_pulse", 16'(err), 16'd0);

    // Restock held during a purchase, accepted once back in IDLE
    sel(2'd0);
    restock_valid = 1'b1; restock_slot = 2'd2; restock_qty = 4'd4;
    step();
    check("e_pay_blocked", 16'(restock_ready), 16'd0);
    coin(4'd3);
    step();
    step();
    step();
    check("e_idle_blocked", {15'd0, restock_ready}, 16'd0);
    check("e_idle_state", 16'(state_o), 16'(S_IDLE));
    step();
    check("e_accept", 16'(restock_ready), 16'd1);
    check("e_stock2_4", 16'(slot_stock(2)), 16'd4);
    check("e_stock0", 16'(slot_stock(0)), 16'd13);
    restock_valid = 1'b0;
    step();
    check("e_ready_pulse", 16'(restock_ready), 16'd0);
    restock_valid = 1'b1; restock_qty = 4'd8;
    step();
    restock_valid = 1'b0;
    check("e_stock2_12", 16'(slot_stock(2)), 16'd12);
    step();
    restock_valid = 1'b1; restock_qty = 4'd10;
    step();
    restock_valid = 1'b0;
    check("e_sat_12p10", 16'(slot_stock(2)), 16'd15);
    step();
    restock_valid = 1'b1; restock_qty = 4'd15;
    step();
    restock_valid = 1'b0;
    check("e_sat_15p15", 16'(slot_stock(2)), 16'd15);
    step();

    // Purchase wins a tie with restock; restock follows after
    sel_valid = 1'b1; sel_slot = 2'd1;
    restock_valid = 1'b1; restock_slot = 2'd1; restock_qty = 4'd1;
    step();
    sel_valid = 1'b0;
    check("f_tie_pay", 16'(state_o), 16'(S_PAY));
    check("f_tie_ready", 16'(restock_ready), 16'd0);
    check("f_tie_stock1", 16'(slot_stock(1)), 16'd14);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("f_refund0", 16'({change_valid, change_amt}), 16'h40);
    step();
    step();
    check("f_late_accept", 16'(restock_ready), 16'd1);
    check("f_stock1", 16'(slot_stock(1)), 16'd15);
    restock_valid = 1'b0;
    step();

    // Credit ceiling: slot 3 priced 63
    sel(2'd3);
    for (int n = 0; n < 6; n++) coin(4'd10);
    check("g_credit60", 16'(credit), 16'd60);
    coin(4'd5);
    check("g_overflow_err", 16'(err), 16'd1);
    check("g_credit_hold", 16'(credit), 16'd60);
    check("g_still_pay", 16'(state_o), 16'(S_PAY));
    coin(4'd3);
    check("g_credit63", 16'(credit), 16'd63);
    check("g_exact_no_err", 16'(err), 16'd0);
    step();
    check("g_dispense", 16'(dispense), 16'd1);
    step();
    check("g_change", 16'({change_valid, change_amt}), 16'h40);
    step();

    // Idle wait in PAY
    sel(2'd1);
    coin(4'd2);
`ifdef VEND_TIMEOUT_EN
    repeat (19) step();
    check("h_before_timeout", 16'(state_o), 16'(S_PAY));
    step();
    check("h_timeout_refund", 16'(state_o), 16'(S_REF));
    check("h_timeout_amt", 16'({change_valid, change_amt}), 16'h42);
`else
    repeat (30) step();
    check("h_no_timeout", 16'(state_o), 16'(S_PAY));
    check("h_credit_kept", 16'(credit), 16'd2);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("h_cancel_amt", 16'({change_valid, change_amt}), 16'h42);
`endif
    step();
    check("h_idle", 16'(state_o), 16'(S_IDLE));
    check("h_stock_all", stock, 16'hEFFD);

    // Asynchronous reset mid-transaction
    sel(2'd0);
    coin(4'd1);
    check("r_credit1", 16'(credit), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("r_async_state", 16'(state_o), 16'(S_IDLE));
    check("r_async_credit", 16'(credit), 16'd0);
    check("r_async_stock", stock, 16'hFFFF);
    check("r_no_refund", 16'(change_valid), 16'd0);
    rst = 1'b0;
    step();
    check("r_after_idle", 16'(state_o), 16'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_seq_ctrl.md
Name: vend_seq_ctrl

Overview:
Purchase/restock sequencer for the 4-slot vending datapath.
- Owns the per-slot stock counters.
- Sequences select -> pay -> dispense -> change.
- Arbitrates admin restock against customer purchases.
- Feeds quantity, credit and change values to the seven-segment display and the LEDs; takes decoded key/button events from the input-processing block.

Parameters:
CAPACITY, 15, max units per slot (4-bit stock).
PRICE0, 3, price of slot 0 in coin units.
PRICE1, 5, price of slot 1.
PRICE2, 7, price of slot 2.
PRICE3, 9, price of slot 3.
TIMEOUT_CYCLES, 100000000, idle cycles in PAY before auto-refund (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sel_valid  in  1  one-cycle pulse: customer selects a slot
sel_slot  in  2  selected slot index
coin_valid  in  1  one-cycle pulse: coin inserted
coin_val  in  4  coin value, 1..10 (0 is ignored)
cancel  in  1  one-cycle pulse: customer abort
restock_valid  in  1  admin restock request (held until accepted)
restock_slot  in  2  slot to restock
restock_qty  in  4  units to add
restock_ready  out  1  restock accepted this cycle
stock  out  16  {slot3,slot2,slot1,slot0} stock, 4 bits each
state_o  out  3  current FSM state code
cur_slot  out  2  slot of the active purchase
credit  out  6  coins inserted in the current transaction
dispense  out  1  one-cycle pulse: item released
change_valid  out  1  one-cycle pulse: change_amt valid
change_amt  out  6  change/refund amount
err  out  1  one-cycle pulse: rejected selection or coin

Behaviour:
- Reset: state IDLE; all stock = CAPACITY; credit=0; cur_slot=0; all pulses and restock_ready = 0; change_amt = 0.
- States: IDLE=0, PAY=1, DISPENSE=2, CHANGE=3, REFUND=4. All outputs are registered.
- IDLE:
  - sel_valid with stock[sel_slot] != 0 -> latch cur_slot; go to PAY next cycle.
  - sel_valid with stock 0 -> err pulse; stay in IDLE.
  - coin_valid in IDLE -> err pulse; coin is ignored.
- Restock:
  - Accepted only in IDLE, and only in a cycle with no sel_valid (purchase wins ties).
  - On acceptance: restock_ready=1 for one cycle; stock = min(stock + qty, CAPACITY). Compute the sum 5-bit, then saturate.
  - Outside IDLE, restock_ready stays 0 and the request waits.
- PAY:
  - coin_valid: credit += coin_val.
  - If credit + coin_val > 63, reject the coin (err pulse, credit unchanged).
  - When credit >= PRICE[cur_slot] (checked on the registered credit) -> DISPENSE.
  - cancel -> REFUND. If cancel and coin arrive in the same cycle, cancel wins and the coin is ignored.
- DISPENSE (1 cycle): dispense=1; stock[cur_slot] -= 1; change_amt = credit - PRICE; -> CHANGE.
- CHANGE (1 cycle): change_valid=1 (change_amt may be 0); credit cleared; -> IDLE.
- REFUND (1 cycle): change_amt = credit; change_valid=1; credit cleared; -> IDLE.
- Latency:
  - Final qualifying coin -> dispense: 2 cycles.
  - dispense -> change_valid: 1 cycle.
- Stock never underflows: entry to PAY requires nonzero stock, and restock is blocked outside IDLE.
- sel_valid outside IDLE is ignored, with no err.
- Asynchronous rst at any point returns to IDLE immediately. Credit is lost with no refund pulse, and stock is reloaded to CAPACITY.

Optional Feature:
VEND_TIMEOUT_EN
- Defined:
  - A timeout counter clears on entry to PAY and on every accepted coin.
  - Reaching TIMEOUT_CYCLES-1 in PAY -> REFUND, same behaviour as cancel.
- Undefined: no counter; PAY waits indefinitely.

Decomposition:
- Package vend_pkg holds:
  - the state enum;
  - CAPACITY_DEF;
  - widths STOCK_W=4, CREDIT_W=6, COIN_W=4;
  - the price lookup function.
- Sub-module vend_stock_bank holds the 4 stock registers and their ports:
  - inputs: dec_en/dec_slot, add_en/add_slot/add_qty with saturation;
  - output: stock.
- vend_seq_ctrl keeps the FSM, credit, arbitration and timeout logic.

Test Plan:
- Select slot 1 (price 5), coins 2,2,2 -> dispense 2 cycles after the third coin; change_amt=1; stock slot1 15->14.
- Select slot 0, coin 3 -> change_valid with change_amt=0.
- Select slot 3, coin 5, then cancel -> REFUND, change_amt=5, stock unchanged, IDLE.
- Slot 2 stock driven to 0 through purchases, then sel slot 2 -> err pulse, stays IDLE.
- Restock during PAY held until IDLE, then accepted. Separately, restock_qty=10 on stock 12 -> stock 15. Simultaneous sel_valid and restock_valid in IDLE -> purchase accepted, restock_ready=0.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=20: select, coin 2, no further input -> REFUND 2 after 20 idle cycles. Separately, credit at 60 plus coin 5 -> err pulse, credit stays 60.
